// File: rtl/flash_pulse_timer.sv
// Flash period timer: latches a 3-bit speed code from the game FSM and emits
// a one-cycle pulse at the end of every flash period, plus a half-period
// flash gate for the LED path.
module flash_pulse_timer #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned BASE_MS  = 800,
    parameter int unsigned STEP_MS  = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_speed,
    input  logic [2:0] speed,
    input  logic       halt,
    output logic       pulse,
    output logic       flash,
    output logic       running,
    output logic [2:0] speed_q
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned PW = $clog2(BASE_MS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] BASE_P    = PW'(BASE_MS);
    localparam logic [PW-1:0] STEP_P    = PW'(STEP_MS);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tick_cnt, tick_nx;
    logic [PW-1:0] period_cnt, period_nx;
    logic [PW-1:0] period_ticks, half_ticks;
    logic [2:0]    speed_nx;
    logic          pulse_nx, flash_nx;
    logic          tick_wrap;

    // Period length in ticks for the latched code, and its flash half
    always_comb begin
        period_ticks = BASE_P - PW'(speed_q) * STEP_P;
        half_ticks   = period_ticks >> 1;
        tick_wrap    = (tick_cnt == TICK_LAST);
    end

    // Next-state, counter and output decode; halt beats load beats terminal count
    always_comb begin
        state_nx  = state;
        tick_nx   = tick_cnt;
        period_nx = period_cnt;
        speed_nx  = speed_q;
        pulse_nx  = 1'b0;
        flash_nx  = 1'b0;
        case (state)
            IDLE: begin
                tick_nx   = '0;
                period_nx = '0;
                if (load_speed && !halt) begin
                    state_nx = RUN;
                    speed_nx = speed;
                end
            end
            RUN: begin
                if (halt) begin
                    state_nx  = IDLE;
                    tick_nx   = '0;
                    period_nx = '0;
                end else if (load_speed) begin
                    speed_nx  = speed;
                    tick_nx   = '0;
                    period_nx = '0;
                end else begin
                    // Gate follows the pre-edge period count, so it rises one edge after a (re)load
                    flash_nx = (period_cnt < half_ticks);
                    if (tick_wrap) begin
                        tick_nx = '0;
                        if (period_cnt == period_ticks - PW'(1)) begin
                            period_nx = '0;
                            pulse_nx  = 1'b1;
                        end else begin
                            period_nx = period_cnt + PW'(1);
                        end
                    end else begin
                        tick_nx = tick_cnt + TW'(1);
                    end
                end
            end
            default: begin
                state_nx  = IDLE;
                tick_nx   = '0;
                period_nx = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            period_cnt <= '0;
            speed_q    <= '0;
            pulse      <= 1'b0;
            flash      <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_nx;
            tick_cnt   <= tick_nx;
            period_cnt <= period_nx;
            speed_q    <= speed_nx;
            pulse      <= pulse_nx;
            flash      <= flash_nx;
            running    <= (state == RUN);
        end
    end

endmodule

// File: tb/tb_flash_pulse_timer.sv
// Directed bench for flash_pulse_timer with a small tick divider so whole
// periods fit in a few dozen cycles (speed 0: 32 cycles, speed 7: 4 cycles).
module tb_flash_pulse_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_speed = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       halt = 1'b0;
    logic       pulse;
    logic       flash;
    logic       running;
    logic [2:0] speed_q;

    int unsigned checks = 0;
    int unsigned errors = 0;

    flash_pulse_timer #(
        .TICK_DIV (4),
        .BASE_MS  (8),
        .STEP_MS  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_speed (load_speed),
        .speed      (speed),
        .halt       (halt),
        .pulse      (pulse),
        .flash      (flash),
        .running    (running),
        .speed_q    (speed_q)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-edge load pulse; returns just after the load edge (edge 0)
    task automatic do_load(input logic [2:0] s);
        load_speed = 1'b1;
        speed      = s;
        step();
        load_speed = 1'b0;
    endtask

    initial begin
        // 1. reset and idle
        repeat (3) step();
        #2 reset_n = 1'b1;
        check("rst_pulse", pulse, 0);
        check("rst_flash", flash, 0);
        check("rst_running", running, 0);
        check("rst_speed_q", speed_q, 0);
        speed = 3'd5;
        for (int n = 1; n <= 100; n++) begin
            step();
            check("idle_pulse", pulse, 0);
            check("idle_flash", flash, 0);
            check("idle_running", running, 0);
            check("idle_speed_q", speed_q, 0);
        end

        // 2. speed 0: P=32, flash high for the first 16 cycles of each period
        do_load(3'd0);
        check("s0_flash_e0", flash, 0);
        for (int n = 1; n <= 100; n++) begin
            step();
            check("s0_pulse", pulse, (n % 32 == 0) ? 1 : 0);
            check("s0_flash", flash, (((n - 1) % 32) < 16) ? 1 : 0);
            check("s0_running", running, 1);
        end
        check("s0_speed_q", speed_q, 0);

        // 3. speed 7: P=4, PT=1 so flash never rises
        do_load(3'd7);
        check("s7_speed_q", speed_q, 7);
        for (int n = 1; n <= 20; n++) begin
            step();
            check("s7_pulse", pulse, (n % 4 == 0) ? 1 : 0);
            check("s7_flash", flash, 0);
        end

        // 4. reload to speed 3 at edge 20 of a speed-0 run; speed changes without load ignored
        do_load(3'd0);
        for (int n = 1; n <= 19; n++) begin
            step();
            check("rl_pre_pulse", pulse, 0);
        end
        load_speed = 1'b1;
        speed      = 3'd3;
        step();
        load_speed = 1'b0;
        speed      = 3'd6;
        check("rl_e20_pulse", pulse, 0);
        check("rl_speed_q", speed_q, 3);
        for (int n = 21; n <= 65; n++) begin
            step();
            check("rl_pulse", pulse, (n == 40 || n == 60) ? 1 : 0);
            check("rl_flash", flash, (((n - 21) % 20) < 8) ? 1 : 0);
            check("rl_speed_q_hold", speed_q, 3);
        end

        // Reload landing on a terminal-count edge suppresses that pulse
        do_load(3'd7);
        for (int n = 1; n <= 3; n++) begin
            step();
            check("tc_pre_pulse", pulse, 0);
        end
        load_speed = 1'b1;
        speed      = 3'd7;
        step();
        load_speed = 1'b0;
        check("tc_reload_pulse", pulse, 0);
        for (int n = 5; n <= 11; n++) begin
            step();
            check("tc_post_pulse", pulse, (n == 8) ? 1 : 0);
        end

        // 5. load and halt together on the terminal edge: halt wins
        load_speed = 1'b1;
        halt       = 1'b1;
        speed      = 3'd2;
        step();
        load_speed = 1'b0;
        halt       = 1'b0;
        check("halt_pulse", pulse, 0);
        check("halt_flash", flash, 0);
        check("halt_speed_q", speed_q, 7);
        step();
        check("halt_running", running, 0);
        for (int n = 0; n < 12; n++) begin
            step();
            check("halt_idle_pulse", pulse, 0);
            check("halt_idle_running", running, 0);
        end

        // 6. asynchronous reset mid-period
        do_load(3'd0);
        repeat (10) step();
        check("ar_pre_flash", flash, 1);
        check("ar_pre_speed", speed_q, 0);
        do_load(3'd4);
        repeat (5) step();
        check("ar_pre_running", running, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_running", running, 0);
        check("ar_flash", flash, 0);
        check("ar_speed_q", speed_q, 0);
        check("ar_pulse", pulse, 0);
        step();
        #3 reset_n = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            check("ar_idle_pulse", pulse, 0);
            check("ar_idle_running", running, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
